spi_master_arb: RTL and testbench

SPI_MASTER_ARB -- requirements
Module: spi_master_arb

---
 rtl/spi_master_arb.sv | 160 ++++++++++++++++
 tb/tb_spi_master_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_master_arb -- two-requester round-robin arbiter driving a 64-bit
// write-only SPI master ({cmd, addr, data}, MSB first, mode 0).
// Rev 1.0
// ============================================================================
module spi_master_arb #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid0,
  input  logic        valid1,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        ready0,
  output logic        ready1,
  output logic        done0,
  output logic        done1,
  output logic        sck,
  output logic        cs,
  output logic        mosi,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_HIGH = 3'd2,
    S_LOW  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [15:0] c_div_reload = 16'(CLK_DIV - 1);
  localparam logic [15:0] c_gap_reload = 16'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  bit_q, bit_d;
  logic [63:0] shreg_q, shreg_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;

  logic        w_idle;
  logic        w_grant;
  logic        w_accept;
  logic        w_cnt_zero;
  logic        w_in_frame;

  // With a single requester it wins outright; the pointer only breaks ties.
  assign w_idle     = (state_q == S_IDLE);
  assign w_grant    = (valid0 & valid1) ? ptr_q : valid1;
  assign w_accept   = w_idle & (valid0 | valid1);
  assign w_cnt_zero = (cnt_q == 16'd0);
  assign w_in_frame = (state_q == S_LEAD) | (state_q == S_HIGH) | (state_q == S_LOW);

  always_comb begin
    state_d = state_q;
    cnt_d   = w_cnt_zero ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (w_accept) begin
          state_d = S_LEAD;
          cnt_d   = c_div_reload;
          shreg_d = w_grant ? {cmd1, addr1, data1} : {cmd0, addr0, data0};
          owner_d = w_grant;
          ptr_d   = ~w_grant;
          bit_d   = 7'd0;
        end
      end
      S_LEAD: begin
        if (w_cnt_zero) begin
          state_d = S_HIGH;
          cnt_d   = c_div_reload;
        end
      end
      S_HIGH: begin
        // Shift on the falling edge so mosi only moves while sck is low.
        if (w_cnt_zero) begin
          state_d = S_LOW;
          cnt_d   = c_div_reload;
          shreg_d = {shreg_q[62:0], 1'b0};
        end
      end
      S_LOW: begin
        if (w_cnt_zero) begin
          if (bit_q == 7'd63) begin
            state_d = S_GAP;
            cnt_d   = c_gap_reload;
            bit_d   = 7'd0;
            done0_d = ~owner_q;
            done1_d = owner_q;
          end else begin
            state_d = S_HIGH;
            cnt_d   = c_div_reload;
            bit_d   = bit_q + 7'd1;
          end
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 7'd0;
      shreg_q <= 64'd0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign ready0 = w_accept & ~w_grant;
  assign ready1 = w_accept & w_grant;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign sck    = (state_q == S_HIGH);
  assign cs     = ~w_in_frame;
  assign mosi   = w_in_frame & shreg_q[63];
  assign busy   = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_master_arb -- random/directed bench with a cycle-level frame model.
// Rev 1.0
// ============================================================================
module tb_spi_master_arb;

  localparam int DIV_A = 4;
  localparam int GAP_A = 2;
  localparam int DIV_B = 1;
  localparam int GAP_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, sel = 1'b0, scramble = 1'b0;
  logic [7:0]  c0 = '0, c1 = '0;
  logic [23:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic ra0, ra1, da0, da1, scka, csa, mosia, busya;
  logic rb0, rb1, db0, db1, sckb, csb, mosib, busyb;

  spi_master_arb #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid0(v0 & ~sel), .valid1(v1 & ~sel),
    .cmd0(c0), .cmd1(c1), .addr0(a0), .addr1(a1), .data0(d0), .data1(d1),
    .ready0(ra0), .ready1(ra1), .done0(da0), .done1(da1),
    .sck(scka), .cs(csa), .mosi(mosia), .busy(busya)
  );

  spi_master_arb #(.CLK_DIV(DIV_B), .CS_GAP(GAP_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid0(v0 & sel), .valid1(v1 & sel),
    .cmd0(c0), .cmd1(c1), .addr0(a0), .addr1(a1), .data0(d0), .data1(d1),
    .ready0(rb0), .ready1(rb1), .done0(db0), .done1(db1),
    .sck(sckb), .cs(csb), .mosi(mosib), .busy(busyb)
  );

  logic m_r0, m_r1, m_d0, m_d1, m_sck, m_cs, m_mosi, m_busy;
  assign m_r0   = sel ? rb0   : ra0;
  assign m_r1   = sel ? rb1   : ra1;
  assign m_d0   = sel ? db0   : da0;
  assign m_d1   = sel ? db1   : da1;
  assign m_sck  = sel ? sckb  : scka;
  assign m_cs   = sel ? csb   : csa;
  assign m_mosi = sel ? mosib : mosia;
  assign m_busy = sel ? busyb : busya;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a frame accepted at sample N keeps the block busy for
  // 129*DIV+GAP samples, cs low for the first 129*DIV of them, done on the next.
  int          busy_left = 0, cur_gap = 0, cur_div = 0, acc_cnt = 0;
  int          mon_bits = 0, high_cnt = 0;
  bit          ptr_m [2];
  bit          cur_owner = 1'b0, seen_frame = 1'b0, g = 1'b0;
  logic [63:0] cur_word = '0, cap = '0, last_word = '0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  int          done_log [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
      busy_left = 0; mon_bits = 0; high_cnt = 0; seen_frame = 1'b0;
      prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
    end else begin
      if (busy_left > 0) begin
        check_eq("busy", 64'(m_busy), 64'd1);
        check_eq("cs", 64'(m_cs), 64'(busy_left <= cur_gap));
        check_eq("done0", 64'(m_d0), 64'(busy_left == cur_gap && cur_owner == 1'b0));
        check_eq("done1", 64'(m_d1), 64'(busy_left == cur_gap && cur_owner == 1'b1));
        check_eq("ready_busy", 64'({m_r0, m_r1}), 64'd0);
        if (busy_left == cur_gap) begin
          check_eq("nbits", 64'(mon_bits), 64'd64);
          check_eq("frame", cap, cur_word);
          last_word = cap;
        end
        busy_left--;
      end else begin
        check_eq("busy_idle", 64'(m_busy), 64'd0);
        check_eq("cs_idle", 64'(m_cs), 64'd1);
        check_eq("done_idle", 64'({m_d0, m_d1}), 64'd0);
        if (v0 || v1) begin
          if (v0 && v1) g = ptr_m[sel];
          else          g = v1;
          check_eq("ready0", 64'(m_r0), 64'(!g));
          check_eq("ready1", 64'(m_r1), 64'(g));
          cur_owner = g;
          cur_word  = g ? {c1, a1, d1} : {c0, a0, d0};
          cur_div   = sel ? DIV_B : DIV_A;
          cur_gap   = sel ? GAP_B : GAP_A;
          busy_left = 129 * cur_div + cur_gap;
          ptr_m[sel] = ~g;
          acc_cnt++;
          mon_bits = 0;
          cap = '0;
        end else begin
          check_eq("ready_none", 64'({m_r0, m_r1}), 64'd0);
        end
      end

      if (!m_cs) begin
        if (m_sck && !prev_sck) begin
          cap = {cap[62:0], m_mosi};
          mon_bits++;
        end
        if (m_sck && prev_sck) check_eq("mosi_stable", 64'(m_mosi), 64'(prev_mosi));
        if (sel && !prev_cs) check_eq("sck_toggle", 64'(m_sck != prev_sck), 64'd1);
        if (prev_cs && seen_frame) check_eq("cs_gap_min", 64'(high_cnt >= cur_gap + 1), 64'd1);
        high_cnt = 0;
        seen_frame = 1'b1;
      end else begin
        check_eq("idle_lines", 64'({m_sck, m_mosi}), 64'd0);
        high_cnt++;
      end

      if (m_d0) done_log.push_back(0);
      if (m_d1) done_log.push_back(1);
      prev_cs = m_cs; prev_sck = m_sck; prev_mosi = m_mosi;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (scramble) begin
      c0 = 8'($urandom);  c1 = 8'($urandom);
      a0 = 24'($urandom); a1 = 24'($urandom);
      d0 = $urandom;      d1 = $urandom;
    end
  endtask

  task automatic wait_acc(input int n);
    int target = acc_cnt + n;
    int budget = n * (129 * DIV_A + 10) + 50;
    while (acc_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("accept_reached", 64'(acc_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int budget = 129 * DIV_A + 50;
    while (busy_left > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check_eq("idle_reached", 64'(busy_left == 0), 64'd1);
  endtask

  task automatic reset_lines(input string tag);
    check_eq({tag, "_cs"},   64'(m_cs),   64'd1);
    check_eq({tag, "_sck"},  64'(m_sck),  64'd0);
    check_eq({tag, "_mosi"}, 64'(m_mosi), 64'd0);
    check_eq({tag, "_busy"}, 64'(m_busy), 64'd0);
    check_eq({tag, "_done"}, 64'({m_d0, m_d1}), 64'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 reset_lines("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int acc0;

  initial begin
    #2 rst_n = 1'b0;
    #1 reset_lines("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed single frame; inputs are scrambled once accepted.
    done_log.delete();
    c0 = 8'hB5; a0 = 24'h123456; d0 = 32'hDEADBEEF; v0 = 1'b1;
    #1 check_eq("ready0_same_cycle", 64'(ra0), 64'd1);
    wait_acc(1);
    v0 = 1'b0;
    scramble = 1'b1;
    wait_idle();
    check_eq("b5_frame", last_word, 64'hB5123456DEADBEEF);
    check_eq("b5_done_cnt", 64'(done_log.size()), 64'd1);
    if (done_log.size() >= 1) check_eq("b5_done_owner", 64'(done_log[0]), 64'd0);

    // Contention from reset: strict alternation starting at requester 0.
    apply_reset();
    done_log.delete();
    v0 = 1'b1; v1 = 1'b1;
    wait_acc(4);
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();
    check_eq("rr_done_cnt", 64'(done_log.size()), 64'd4);
    for (int i = 0; i < done_log.size(); i++) check_eq("rr_order", 64'(done_log[i]), 64'(i % 2));

    // Back-to-back frames from requester 1.
    done_log.delete();
    v1 = 1'b1;
    wait_acc(3);
    v1 = 1'b0;
    wait_idle();
    check_eq("b2b_done_cnt", 64'(done_log.size()), 64'd3);
    for (int i = 0; i < done_log.size(); i++) check_eq("b2b_owner", 64'(done_log[i]), 64'd1);

    // Random request toggling, including withdrawals while busy.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) v0 = ~v0;
      if ($urandom_range(0, 7) == 0) v1 = ~v1;
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Reset in the middle of a frame, then an immediate fresh accept.
    done_log.delete();
    v0 = 1'b1;
    wait_acc(1);
    v0 = 1'b0;
    begin
      int budget = 400;
      while (mon_bits < 20 && budget > 0) begin
        tick();
        budget--;
      end
    end
    check_eq("bit20_reached", 64'(mon_bits >= 20), 64'd1);
    rst_n = 1'b0;
    #1 reset_lines("abort");
    check_eq("abort_no_done", 64'(done_log.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    v1 = 1'b1;
    acc0 = acc_cnt;
    tick();
    check_eq("first_edge_accept", 64'(acc_cnt), 64'(acc0 + 1));
    v1 = 1'b0;
    wait_idle();
    check_eq("post_rst_done_cnt", 64'(done_log.size()), 64'd1);
    if (done_log.size() >= 1) check_eq("post_rst_owner", 64'(done_log[0]), 64'd1);

    // Fastest divider instance.
    sel = 1'b1;
    done_log.delete();
    v0 = 1'b1; v1 = 1'b1;
    wait_acc(4);
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();
    check_eq("div1_done_cnt", 64'(done_log.size()), 64'd4);
    for (int i = 0; i < done_log.size(); i++) check_eq("div1_order", 64'(done_log[i]), 64'(i % 2));
    for (int i = 0; i < 800; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) v0 = ~v0;
      if ($urandom_range(0, 3) == 0) v1 = ~v1;
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
